// File: rtl/ex_branch_resolve_pkg.sv
// Shared definitions for the EX->MEM branch-resolve slice.
//   XLEN          : datapath width
//   GHR_W         : global-history width carried with each branch
//   train_entry_t : perceptron training record {pc, ghr, taken, mispred}
package ex_branch_resolve_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned GHR_W = 16;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [GHR_W-1:0] ghr;
    logic             taken;
    logic             mispred;
  } train_entry_t;

endpackage

// File: rtl/ex_branch_resolve_train_fifo.sv
// Small FIFO buffering perceptron training updates.
//   clk, reset   : clock, synchronous active-high reset (clears pointers/count)
//   i_push       : write i_data (ignored while full)
//   i_data       : entry to write
//   i_pop_ready  : consumer accepts the head; pops when not empty
//   o_data       : head entry, stable until popped
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
module train_fifo
  import ex_branch_resolve_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  train_entry_t i_data,
  input  logic         i_pop_ready,
  output train_entry_t o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  train_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop_ready & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= f_next(r_wr);
      if (w_pop)  r_rd <= f_next(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// EX->MEM stage behind the ALU: resolves branches/jumps, detects perceptron
// mispredictions, issues a one-cycle redirect, registers the EX/MEM boundary
// and buffers training updates.
//   clk, reset                    : clock, synchronous active-high reset
//   exValid..branchFlag, memStall : EX instruction, ALU outputs, MEM backpressure
//   resolveStall                  : hold EX upstream (training FIFO full)
//   mem*                          : registered EX/MEM payload
//   redirectValid, redirectPc     : one-cycle flush pulse and correct next PC
//   train*, trainReady            : training FIFO head (valid/ready)
//   mispredCnt                    : saturating mispredict count
module ex_branch_resolve
  import ex_branch_resolve_pkg::*;
#(
  parameter int unsigned XLEN        = ex_branch_resolve_pkg::XLEN,
  parameter int unsigned GHR_W       = ex_branch_resolve_pkg::GHR_W,
  parameter int unsigned TRAIN_DEPTH = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exValid,
  input  logic [XLEN-1:0]  exPc,
  input  logic [XLEN-1:0]  exImm,
  input  logic             exBranch,
  input  logic             exJal,
  input  logic             exJalr,
  input  logic             exPredTaken,
  input  logic [XLEN-1:0]  exPredTarget,
  input  logic [GHR_W-1:0] exGhr,
  input  logic [4:0]       exRd,
  input  logic             exRegWrite,
  input  logic             exMemRead,
  input  logic             exMemWrite,
  input  logic [XLEN-1:0]  exStoreData,
  input  logic [XLEN-1:0]  aluResult,
  input  logic             branchFlag,
  input  logic             memStall,
  output logic             resolveStall,
  output logic             memValid,
  output logic [XLEN-1:0]  memResult,
  output logic [4:0]       memRd,
  output logic             memRegWrite,
  output logic             memMemRead,
  output logic             memMemWrite,
  output logic [XLEN-1:0]  memStoreData,
  output logic             redirectValid,
  output logic [XLEN-1:0]  redirectPc,
  output logic             trainValid,
  input  logic             trainReady,
  output logic [XLEN-1:0]  trainPc,
  output logic [GHR_W-1:0] trainGhr,
  output logic             trainTaken,
  output logic             trainMispred,
  output logic [CNT_W-1:0] mispredCnt
);

  logic             w_taken;
  logic             w_mispred;
  logic             w_fire;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_pc4;
  train_entry_t     w_entry;
  train_entry_t     w_head;

  logic             r_memValid;
  logic [XLEN-1:0]  r_memResult;
  logic [4:0]       r_memRd;
  logic             r_memRegWrite;
  logic             r_memMemRead;
  logic             r_memMemWrite;
  logic [XLEN-1:0]  r_memStoreData;
  logic             r_redirectValid;
  logic [XLEN-1:0]  r_redirectPc;
  logic [CNT_W-1:0] r_mispredCnt;

  assign w_pc4     = exPc + XLEN'(4);
  assign w_target  = exJalr ? (aluResult & ~XLEN'(1)) : (exPc + exImm);
  assign w_taken   = exBranch ? branchFlag : (exJal | exJalr);
  assign w_mispred = (w_taken != exPredTaken) | (w_taken & (w_target != exPredTarget));

  // Stall depends only on registered FIFO state, never on trainReady.
  assign resolveStall = exValid & exBranch & w_full;
  // A live redirect squashes whatever EX presents in that cycle.
  assign w_fire = exValid & ~memStall & ~resolveStall & ~r_redirectValid;
  assign w_push = w_fire & exBranch;

  always_comb begin
    w_entry         = '0;
    w_entry.pc      = exPc;
    w_entry.ghr     = exGhr;
    w_entry.taken   = w_taken;
    w_entry.mispred = w_mispred;
  end

  train_fifo #(
    .DEPTH (TRAIN_DEPTH)
  ) u_train_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_data      (w_entry),
    .i_pop_ready (trainReady),
    .o_data      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_memValid      <= 1'b0;
      r_memResult     <= '0;
      r_memRd         <= '0;
      r_memRegWrite   <= 1'b0;
      r_memMemRead    <= 1'b0;
      r_memMemWrite   <= 1'b0;
      r_memStoreData  <= '0;
      r_redirectValid <= 1'b0;
      r_redirectPc    <= '0;
      r_mispredCnt    <= '0;
    end else begin
      r_redirectValid <= w_fire & w_mispred;
      if (w_fire & w_mispred) begin
        r_redirectPc <= w_taken ? w_target : w_pc4;
        if (r_mispredCnt != '1) r_mispredCnt <= r_mispredCnt + CNT_W'(1);
      end
      if (!memStall) begin
        r_memValid <= w_fire;
        if (w_fire) begin
          r_memResult    <= (exJal | exJalr) ? w_pc4 : aluResult;
          r_memRd        <= exRd;
          r_memRegWrite  <= exRegWrite;
          r_memMemRead   <= exMemRead;
          r_memMemWrite  <= exMemWrite;
          r_memStoreData <= exStoreData;
        end
      end
    end
  end

  assign memValid      = r_memValid;
  assign memResult     = r_memResult;
  assign memRd         = r_memRd;
  assign memRegWrite   = r_memRegWrite;
  assign memMemRead    = r_memMemRead;
  assign memMemWrite   = r_memMemWrite;
  assign memStoreData  = r_memStoreData;
  assign redirectValid = r_redirectValid;
  assign redirectPc    = r_redirectPc;
  assign mispredCnt    = r_mispredCnt;
  assign trainValid    = ~w_empty;
  assign trainPc       = w_head.pc;
  assign trainGhr      = w_head.ghr;
  assign trainTaken    = w_head.taken;
  assign trainMispred  = w_head.mispred;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Self-checking bench for ex_branch_resolve: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_ex_branch_resolve;

  localparam int XLEN  = 32;
  localparam int GHR_W = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, exValid, exBranch, exJal, exJalr, exPredTaken;
  logic [XLEN-1:0]  exPc, exImm, exPredTarget, exStoreData, aluResult;
  logic [GHR_W-1:0] exGhr;
  logic [4:0]       exRd;
  logic             exRegWrite, exMemRead, exMemWrite, branchFlag, memStall;
  logic             resolveStall, memValid, memRegWrite, memMemRead, memMemWrite;
  logic [XLEN-1:0]  memResult, memStoreData, redirectPc, trainPc;
  logic [4:0]       memRd;
  logic             redirectValid, trainValid, trainReady, trainTaken, trainMispred;
  logic [GHR_W-1:0] trainGhr;
  logic [CNT_W-1:0] mispredCnt;

  ex_branch_resolve #(
    .XLEN(XLEN), .GHR_W(GHR_W), .TRAIN_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .exValid(exValid), .exPc(exPc), .exImm(exImm),
    .exBranch(exBranch), .exJal(exJal), .exJalr(exJalr), .exPredTaken(exPredTaken),
    .exPredTarget(exPredTarget), .exGhr(exGhr), .exRd(exRd), .exRegWrite(exRegWrite),
    .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exStoreData(exStoreData),
    .aluResult(aluResult), .branchFlag(branchFlag), .memStall(memStall),
    .resolveStall(resolveStall), .memValid(memValid), .memResult(memResult),
    .memRd(memRd), .memRegWrite(memRegWrite), .memMemRead(memMemRead),
    .memMemWrite(memMemWrite), .memStoreData(memStoreData),
    .redirectValid(redirectValid), .redirectPc(redirectPc), .trainValid(trainValid),
    .trainReady(trainReady), .trainPc(trainPc), .trainGhr(trainGhr),
    .trainTaken(trainTaken), .trainMispred(trainMispred), .mispredCnt(mispredCnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    logic [15:0] ghr;
    logic        taken;
    logic        mis;
  } ent_t;
  ent_t        q[$];
  logic        m_memValid, m_memRegWrite, m_memRead, m_memWrite, m_redir;
  logic [31:0] m_memResult, m_storeData, m_redirPc;
  logic [4:0]  m_memRd;
  int          m_cnt;

  task automatic model_clear();
    q.delete();
    m_memValid = 0; m_memResult = 0; m_memRd = 0; m_memRegWrite = 0;
    m_memRead = 0; m_memWrite = 0; m_storeData = 0;
    m_redir = 0; m_redirPc = 0; m_cnt = 0;
  endtask

  // One clock: check the combinational stall, advance the model, check all outputs.
  task automatic step();
    logic        taken, mis, fire, stall;
    logic [31:0] tgt, pc4;
    ent_t        e;
    #1;
    stall = exValid && exBranch && (q.size() == DEPTH);
    chk("resolveStall", resolveStall, stall);
    taken = exBranch ? branchFlag : (exJal || exJalr);
    tgt   = exJalr ? {aluResult[31:1], 1'b0} : exPc + exImm;
    pc4   = exPc + 32'd4;
    mis   = (taken != exPredTaken) || (taken && tgt != exPredTarget);
    fire  = exValid && !memStall && !stall && !m_redir;
    @(posedge clk);
    #1;
    if (reset) begin
      model_clear();
    end else begin
      if (q.size() > 0 && trainReady) void'(q.pop_front());
      if (fire && exBranch) begin
        e.pc = exPc; e.ghr = exGhr; e.taken = taken; e.mis = mis;
        q.push_back(e);
      end
      m_redir = fire && mis;
      if (fire && mis) begin
        m_redirPc = taken ? tgt : pc4;
        if (m_cnt < CMAX) m_cnt++;
      end
      if (!memStall) begin
        m_memValid = fire;
        if (fire) begin
          m_memResult = (exJal || exJalr) ? pc4 : aluResult;
          m_memRd = exRd; m_memRegWrite = exRegWrite;
          m_memRead = exMemRead; m_memWrite = exMemWrite; m_storeData = exStoreData;
        end
      end
    end
    chk("memValid", memValid, m_memValid);
    chk("memResult", memResult, m_memResult);
    chk("memRd", memRd, m_memRd);
    chk("memRegWrite", memRegWrite, m_memRegWrite);
    chk("memMemRead", memMemRead, m_memRead);
    chk("memMemWrite", memMemWrite, m_memWrite);
    chk("memStoreData", memStoreData, m_storeData);
    chk("redirectValid", redirectValid, m_redir);
    chk("redirectPc", redirectPc, m_redirPc);
    chk("mispredCnt", mispredCnt, 64'(m_cnt));
    chk("trainValid", trainValid, q.size() > 0);
    if (q.size() > 0) begin
      chk("trainPc", trainPc, q[0].pc);
      chk("trainGhr", trainGhr, q[0].ghr);
      chk("trainTaken", trainTaken, q[0].taken);
      chk("trainMispred", trainMispred, q[0].mis);
    end
  endtask

  task automatic idle();
    exValid = 0; memStall = 0; reset = 0; trainReady = 1;
    step();
  endtask

  // kind: 0 alu, 1 branch, 2 jal, 3 jalr
  task automatic set_ins(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                         input logic flag, input logic pt, input logic [31:0] ptgt,
                         input logic [31:0] alu);
    exValid = 1; exPc = pc; exImm = imm; branchFlag = flag; exPredTaken = pt;
    exPredTarget = ptgt; aluResult = alu;
    exBranch = (kind == 1); exJal = (kind == 2); exJalr = (kind == 3);
    exGhr = GHR_W'($urandom); exRd = 5'($urandom); exRegWrite = 1'($urandom);
    exMemRead = 0; exMemWrite = 0; exStoreData = $urandom;
  endtask

  typedef struct {
    int          kind;
    logic [31:0] pc, imm, alu, ptgt;
    logic        flag, pt;
    logic        e_redir;
    logic [31:0] e_rpc, e_res;
  } vec_t;

  function automatic vec_t mkv(int k, logic [31:0] pc, logic [31:0] imm, logic [31:0] alu,
                               logic [31:0] ptgt, logic flag, logic pt, logic er,
                               logic [31:0] rpc, logic [31:0] res);
    vec_t v;
    v.kind = k; v.pc = pc; v.imm = imm; v.alu = alu; v.ptgt = ptgt; v.flag = flag;
    v.pt = pt; v.e_redir = er; v.e_rpc = rpc; v.e_res = res;
    return v;
  endfunction

  vec_t tv[11];

  initial begin
    tv[0]  = mkv(1, 32'h100, 32'h20, 32'h0, 32'h0, 1, 0, 1, 32'h120, 32'h0);
    tv[1]  = mkv(3, 32'h200, 32'h0, 32'h2003, 32'h2002, 0, 1, 0, 32'h0, 32'h204);
    tv[2]  = mkv(3, 32'h200, 32'h0, 32'h2003, 32'h2000, 0, 1, 1, 32'h2002, 32'h204);
    tv[3]  = mkv(1, 32'h40, 32'h80, 32'h55, 32'h0, 0, 0, 0, 32'h0, 32'h55);
    tv[4]  = mkv(1, 32'h40, 32'h80, 32'h66, 32'hC0, 0, 1, 1, 32'h44, 32'h66);
    tv[5]  = mkv(2, 32'h300, 32'hFFFFFFF0, 32'h7, 32'h2F0, 0, 1, 0, 32'h0, 32'h304);
    tv[6]  = mkv(2, 32'h300, 32'h10, 32'h7, 32'h0, 0, 0, 1, 32'h310, 32'h304);
    tv[7]  = mkv(1, 32'h500, 32'h8, 32'h1, 32'h508, 1, 1, 0, 32'h0, 32'h1);
    tv[8]  = mkv(1, 32'h500, 32'h8, 32'h1, 32'h50C, 1, 1, 1, 32'h508, 32'h1);
    tv[9]  = mkv(2, 32'hFFFFFFFC, 32'h8, 32'h9, 32'h0, 0, 0, 1, 32'h4, 32'h0);
    tv[10] = mkv(0, 32'h600, 32'h4, 32'h1234, 32'h0, 0, 0, 0, 32'h0, 32'h1234);

    exValid = 0; exPc = 0; exImm = 0; exBranch = 0; exJal = 0; exJalr = 0;
    exPredTaken = 0; exPredTarget = 0; exGhr = 0; exRd = 0; exRegWrite = 0;
    exMemRead = 0; exMemWrite = 0; exStoreData = 0; aluResult = 0; branchFlag = 0;
    memStall = 0; trainReady = 1; reset = 1;
    model_clear();
    step();
    chk("rst_memValid", memValid, 0);
    chk("rst_trainValid", trainValid, 0);
    chk("rst_cnt", mispredCnt, 0);
    idle();

    // Directed vectors, each followed by an idle cycle to clear any redirect
    for (int i = 0; i < 11; i++) begin
      set_ins(tv[i].kind, tv[i].pc, tv[i].imm, tv[i].flag, tv[i].pt, tv[i].ptgt, tv[i].alu);
      step();
      chk("vec_memValid", memValid, 1);
      chk("vec_redir", redirectValid, tv[i].e_redir);
      if (tv[i].e_redir) chk("vec_redirPc", redirectPc, tv[i].e_rpc);
      chk("vec_memResult", memResult, tv[i].e_res);
      if (i == 0) begin
        chk("beq_cnt", mispredCnt, 1);
        chk("beq_trainPc", trainPc, 32'h100);
        chk("beq_trainTaken", trainTaken, 1);
        chk("beq_trainMis", trainMispred, 1);
      end
      if (i == 3) chk("bne_trainMis", trainMispred, 0);
      idle();
    end

    // Instruction presented during a redirect is squashed
    set_ins(1, 32'h100, 32'h20, 1, 0, 32'h0, 32'h0);
    step();
    set_ins(0, 32'h104, 32'h0, 0, 0, 32'h0, 32'hAB);
    step();
    chk("squash_memValid", memValid, 0);
    chk("squash_redir", redirectValid, 0);
    idle(); idle(); idle();

    // FIFO full: third branch stalls until a pop, then fires
    trainReady = 0;
    set_ins(1, 32'h600, 32'h8, 0, 0, 32'h0, 32'h0); exValid = 1; memStall = 0;
    step();
    set_ins(1, 32'h604, 32'h8, 0, 0, 32'h0, 32'h0);
    step();
    set_ins(1, 32'h608, 32'h8, 0, 0, 32'h0, 32'h0);
    step();
    chk("full_memValid", memValid, 0);
    step();
    chk("full_hold_stall", resolveStall, 1);
    trainReady = 1;
    step();
    chk("pop_cycle_memValid", memValid, 0);
    chk("pop_head", trainPc, 32'h604);
    trainReady = 0;
    step();
    chk("third_fired", memValid, 1);
    idle(); idle(); idle();

    // memStall holds a mispredicting branch; release gives one redirect, one push
    set_ins(1, 32'h700, 32'h10, 1, 0, 32'h0, 32'h0);
    memStall = 1;
    step();
    step();
    chk("stall_noredir", redirectValid, 0);
    chk("stall_nopush", trainValid, 0);
    memStall = 0;
    step();
    chk("rel_redir", redirectValid, 1);
    chk("rel_redirPc", redirectPc, 32'h710);
    chk("rel_push", trainPc, 32'h700);
    idle();
    chk("rel_single", redirectValid, 0);
    idle(); idle();

    // Reset with redirect pending and two queued updates
    trainReady = 0;
    set_ins(1, 32'h900, 32'h8, 0, 0, 32'h0, 32'h0);
    step();
    set_ins(1, 32'h904, 32'h8, 0, 0, 32'h0, 32'h0);
    step();
    set_ins(2, 32'h800, 32'h40, 0, 0, 32'h0, 32'h0);
    step();
    chk("pre_rst_redir", redirectValid, 1);
    exValid = 0; reset = 1;
    step();
    chk("rstd_redir", redirectValid, 0);
    chk("rstd_trainValid", trainValid, 0);
    chk("rstd_memValid", memValid, 0);
    chk("rstd_cnt", mispredCnt, 0);
    reset = 0;
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int k;
      logic [31:0] pc, imm, alu, tgt;
      logic flag, pt;
      k = $urandom_range(0, 3);
      pc = {$urandom_range(0, 255), 2'b00}; imm = {$urandom_range(0, 63), 2'b00};
      alu = $urandom; flag = 1'($urandom); pt = 1'($urandom);
      tgt = (k == 3) ? {alu[31:1], 1'b0} : pc + imm;
      if ($urandom_range(0, 3) == 0) tgt = tgt + 32'h4;
      set_ins(k, pc, imm, flag, pt, tgt, alu);
      exMemRead = 1'($urandom); exMemWrite = 1'($urandom);
      exValid = ($urandom_range(0, 3) != 0);
      memStall = ($urandom_range(0, 4) == 0);
      trainReady = 1'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
